// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, ALU codes, FSM state
// encodings and decoded instruction classes.
package multicycle_ctrl_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned STATE_W = 3;

  localparam logic [OPC_W-1:0] OPC_ADD  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ADDI = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LW   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_SW   = 7'b0100011;

  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_PASS = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Combinational opcode decode: instruction class and the ALU operation used in EX.
module multicycle_ctrl_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_e        op_class_c,
  output logic [ALU_W-1:0] alu_ctl_c
);

  always_comb begin
    op_class_c = CLS_ILLEGAL;
    alu_ctl_c  = ALU_PASS;
    case (opcode)
      OPC_ADD, OPC_ADDI: begin
        op_class_c = CLS_ALU;
        alu_ctl_c  = ALU_ADD;
      end
      OPC_LW: begin
        op_class_c = CLS_LOAD;
        alu_ctl_c  = ALU_ADD;
      end
      OPC_SW: begin
        op_class_c = CLS_STORE;
        alu_ctl_c  = ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB controller with retired-instruction counter and sticky error.
// Optional macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt instead of acting as NOP.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               ir_load,
  output logic               write_en,
  output logic [ALU_W-1:0]   ALU_CTL,
  output logic               data_rom_write_en,
  output logic               data_rom_read_en,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retired,
  output logic               err
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              wait_inc;
  logic              retire;
  logic              set_err;
  op_class_e         op_class;
  logic [ALU_W-1:0]  dec_alu;

  multicycle_ctrl_dec u_dec (
    .opcode     (opcode),
    .op_class_c (op_class),
    .alu_ctl_c  (dec_alu)
  );

  assign state = state_q;

  // Strobes are decoded from the current state (and mem_ready in MEM) so that the
  // completing MEM cycle can raise pc_en in the same cycle the handshake lands.
  always_comb begin
    state_d           = state_q;
    pc_en             = 1'b0;
    ir_load           = 1'b0;
    write_en          = 1'b0;
    ALU_CTL           = ALU_PASS;
    data_rom_read_en  = 1'b0;
    data_rom_write_en = 1'b0;
    retire            = 1'b0;
    set_err           = 1'b0;
    wait_inc          = 1'b0;
    case (state_q)
      S_IF: begin
        ir_load = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (op_class == CLS_ILLEGAL) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          set_err = 1'b1;
          state_d = S_HALT;
`else
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_d = S_IF;
`endif
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        ALU_CTL = dec_alu;
        state_d = (op_class == CLS_LOAD || op_class == CLS_STORE) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          // Timeout: request already dropped, instruction abandoned without retiring.
          pc_en   = 1'b1;
          set_err = 1'b1;
          state_d = S_IF;
        end else begin
          data_rom_read_en  = (op_class == CLS_LOAD);
          data_rom_write_en = (op_class == CLS_STORE);
          if (mem_ready) begin
            if (op_class == CLS_LOAD) begin
              state_d = S_WB;
            end else begin
              pc_en   = 1'b1;
              retire  = 1'b1;
              state_d = S_IF;
            end
          end else begin
            wait_inc = 1'b1;
          end
        end
      end
      S_WB: begin
        write_en = 1'b1;
        pc_en    = 1'b1;
        retire   = 1'b1;
        state_d  = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    // Reset silences every strobe immediately, independent of the clock.
    if (rst) begin
      pc_en             = 1'b0;
      ir_load           = 1'b0;
      write_en          = 1'b0;
      ALU_CTL           = ALU_PASS;
      data_rom_read_en  = 1'b0;
      data_rom_write_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      retired <= '0;
      err     <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
      if (set_err) err <= 1'b1;
      wait_q <= wait_inc ? wait_q + WAIT_W'(1) : '0;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of retired-instruction counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, max wait cycles for mem_ready before error.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port opcode  input  7  instruction[6:0] from instruction register.
REQ-006 SHALL have port mem_ready  input  1  data memory completed current request.
REQ-007 SHALL have port pc_en  output  1  PC update strobe.
REQ-008 SHALL have port ir_load  output  1  instruction register load strobe.
REQ-009 SHALL have port write_en  output  1  register-file write strobe.
REQ-010 SHALL have port ALU_CTL  output  3  ALU operation; 3'b000 add, 3'b111 pass/none.
REQ-011 SHALL have port data_rom_write_en  output  1  data memory write request.
REQ-012 SHALL have port data_rom_read_en  output  1  data memory read request.
REQ-013 SHALL have port state  output  3  current FSM state encoding.
REQ-014 SHALL have port retired  output  CNT_W  count of completed instructions.
REQ-015 SHALL have port err  output  1  sticky error flag (illegal opcode or memory timeout).

Function
REQ-016 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7.
REQ-017 IF: ir_load=1 one cycle; next ID.
REQ-018 ID: decode opcode; add/addi/lw/sw -> EX; any other -> IF (treated as NOP, pc_en=1 in that ID cycle, retired increments).
REQ-019 EX: ALU_CTL=000 for add, addi, lw, sw; next MEM for lw/sw, WB for add/addi.
REQ-020 ALU_CTL SHALL be 3'b111 in every state other than EX.
REQ-021 MEM: assert data_rom_read_en (lw) or data_rom_write_en (sw) continuously until mem_ready sampled high; then lw -> WB, sw -> IF with pc_en=1 that cycle.
REQ-022 mem_ready outside MEM SHALL be ignored.
REQ-023 MEM wait counter SHALL count cycles without mem_ready; reaching MEM_TIMEOUT SHALL set err, drop requests, go IF with pc_en=1 (instruction abandoned, not retired).
REQ-024 WB: write_en=1 one cycle, pc_en=1; next IF.
REQ-025 retired SHALL increment by 1 on every pc_en pulse except timeout abandonment; wraps from all-ones to 0.
REQ-026 Latency: add/addi 4 cycles, lw 5+wait, sw 4+wait, NOP 2.
REQ-027 All strobes SHALL be mutually exclusive except pc_en with write_en or data_rom_write_en.

Reset
REQ-028 rst high SHALL asynchronously force state=IF, all strobes 0, ALU_CTL=111, retired=0, err=0, wait counter 0.
REQ-029 rst mid-MEM SHALL drop data_rom_*_en immediately, without waiting for mem_ready.
REQ-030 First IF after rst release SHALL assert ir_load in the first clock.

Configuration
REQ-031 Macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: defined -> illegal opcode in ID sets err and enters HALT, all strobes 0, exit only by rst.
REQ-032 Undefined -> illegal opcode is NOP per REQ-018, err unaffected by it; HALT unreachable.

Structure
REQ-033 Opcode constants (add, addi, lw, sw) and state encodings SHALL live in the shared define file.
REQ-034 Opcode-to-ALU_CTL/class decode SHALL be one combinational sub-module multicycle_ctrl_dec.

Verification
REQ-035 add (0110011): IF,ID,EX,WB; write_en one cycle at WB, ALU_CTL=000 only in EX, retired 0->1.
REQ-036 lw (0000011), mem_ready after 3 cycles: read_en held 3 cycles then WB write_en; retired=1.
REQ-037 sw (0100011), mem_ready never: write_en-to-memory held 15 cycles, err=1, back to IF, retired unchanged.
REQ-038 opcode 1111111: without macro IF->ID->IF, retired+1, err=0; with macro HALT, err=1, stays until rst.
REQ-039 rst asserted during MEM of lw: data_rom_read_en=0 same cycle, state=IF, retired=0.
REQ-040 CNT_W=4, 16 adds: retired wraps 15->0.
